// File: rtl/data_mem_pkg.sv
// Shared constants and types for the datapath data memory.
// Default geometry is 32 x 32-bit words.
package data_mem_pkg;

    localparam int DMEM_W = 32;
    localparam int DMEM_N = 5;

    typedef logic [DMEM_W-1:0] dmem_word_t;

    function automatic int dmem_depth(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Storage array with synchronous clear and one write port; mem[a+1] holds word a.
// Latency: write visible in mem right after the sampling edge.
// Backpressure: none, one write per cycle is always accepted.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int W = DMEM_W,
    parameter int N = DMEM_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] address,
    input  logic         write_en,
    input  logic [W-1:0] write_data,
    output logic [W-1:0] mem [1:dmem_depth(N)]
);

    localparam int DEPTH = dmem_depth(N);

    // One extra bit so the top word lands on mem[DEPTH] without wrapping.
    logic [N:0] idx;
    assign idx = {1'b0, address} + (N+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en) begin
            mem[idx] <= write_data;
        end
    end

endmodule

// File: rtl/data_mem.sv
// Single-port data memory for the memory stage; DATA_MEM_WRITE_FWD_EN selects write-first collisions.
// Latency: read data registered, valid one cycle after MemRead; writes land at the edge.
// Backpressure: none, always ready for one read and one write per cycle.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int W = DMEM_W,
    parameter int N = DMEM_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] address,
    input  logic         MemWrite,
    input  logic         MemRead,
    input  logic [W-1:0] write_data,
    output logic [W-1:0] read_data
);

    localparam int DEPTH = dmem_depth(N);

    // Top-level alias keeps the storage reachable as <inst>.mem.
    logic [W-1:0] mem [1:DEPTH];

    logic [N:0] idx;
    assign idx = {1'b0, address} + (N+1)'(1);

    data_mem_array #(
        .W (W),
        .N (N)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .write_en   (MemWrite),
        .write_data (write_data),
        .mem        (mem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (MemRead) begin
`ifdef DATA_MEM_WRITE_FWD_EN
            if (MemWrite) begin
                read_data <= write_data;
            end else begin
                read_data <= mem[idx];
            end
`else
            read_data <= mem[idx];
`endif
        end
    end

`ifndef SYNTHESIS
    a_addr_known: assert property (@(posedge clk) disable iff (rst)
        (MemRead || MemWrite) |-> !$isunknown(address))
        else $error("data_mem: X/Z on address during access");
`endif

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem (default W=32, N=5).
module tb_data_mem;

    logic        clk;
    logic        rst;
    logic [4:0]  address;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int n_checks;
    int n_fail;
    logic [31:0] wdata [0:31];

    data_mem #(.W(32), .N(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        address    = '0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        write_data = '0;

        step();
        check("reset_read_data", read_data, 32'h0);
        for (int i = 1; i <= 32; i++) begin
            check($sformatf("reset_mem[%0d]", i), dut.mem[i], 32'h0);
        end
        rst = 1'b0;

        // Disabled write must not touch storage.
        address    = 5'd2;
        write_data = 32'hFFFF_0000;
        step();
        check("no_write_mem[3]", dut.mem[3], 32'h0);

        for (int i = 0; i < 32; i++) begin
            wdata[i] = $urandom;
        end
        MemWrite = 1'b1;
        for (int i = 0; i < 32; i++) begin
            address    = 5'(i);
            write_data = wdata[i];
            step();
            check($sformatf("write_mem[%0d]", i + 1), dut.mem[i + 1], wdata[i]);
        end
        MemWrite = 1'b0;

        MemRead = 1'b1;
        for (int i = 0; i < 32; i++) begin
            address = 5'(i);
            step();
            check($sformatf("read_addr%0d", i), read_data, wdata[i]);
        end

        // Hold: value stays when MemRead drops and address moves.
        MemRead    = 1'b0;
        MemWrite   = 1'b1;
        address    = 5'd5;
        write_data = 32'hDEAD_BEEF;
        step();
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        step();
        check("hold_read", read_data, 32'hDEAD_BEEF);
        MemRead = 1'b0;
        address = 5'd6;
        step();
        check("hold_1", read_data, 32'hDEAD_BEEF);
        step();
        check("hold_2", read_data, 32'hDEAD_BEEF);

        // Collision on address 7.
        MemWrite   = 1'b1;
        address    = 5'd7;
        write_data = 32'h1111_1111;
        step();
        MemRead    = 1'b1;
        write_data = 32'h2222_2222;
        step();
`ifdef DATA_MEM_WRITE_FWD_EN
        check("collision_read", read_data, 32'h2222_2222);
`else
        check("collision_read", read_data, 32'h1111_1111);
`endif
        check("collision_mem[8]", dut.mem[8], 32'h2222_2222);
        MemWrite = 1'b0;
        step();
        check("after_collision_read", read_data, 32'h2222_2222);

        // Reset mid-stream swallows a concurrent write.
        MemRead    = 1'b0;
        MemWrite   = 1'b1;
        address    = 5'd3;
        write_data = 32'hA5A5_A5A5;
        rst        = 1'b1;
        step();
        check("rst_mid_mem[4]", dut.mem[4], 32'h0);
        check("rst_mid_mem[1]", dut.mem[1], 32'h0);
        check("rst_mid_mem[32]", dut.mem[32], 32'h0);
        check("rst_mid_read_data", read_data, 32'h0);
        rst      = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        step();
        check("rst_mid_readback", read_data, 32'h0);

        // Top address after reset, write then read next cycle.
        MemRead    = 1'b0;
        MemWrite   = 1'b1;
        address    = 5'd31;
        write_data = 32'h0BAD_CAFE;
        step();
        check("top_mem[32]", dut.mem[32], 32'h0BAD_CAFE);
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        step();
        check("top_read", read_data, 32'h0BAD_CAFE);
        MemRead = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
